// File: rtl/reg_file_wsched.sv
// Round-robin write-port scheduler feeding the two write ports (C, D) of an 8 x 16 register file.
// Define RF_WSCHED_STATS_EN to add saturating grant/conflict counters (grant_cnt_out, conflict_cnt_out).
module reg_file_wsched #(
    parameter int NREQ = 4,
    parameter int AW   = 3,
    parameter int DW   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sched_en_in,
    input  logic [NREQ-1:0]      req_valid_in,
    input  logic [NREQ*AW-1:0]   req_addr_in,
    input  logic [NREQ*DW-1:0]   req_data_in,
    output logic [NREQ-1:0]      req_ready_out,
    output logic                 r_c_wen_out,
    output logic [AW-1:0]        r_c_waddr_out,
    output logic [DW-1:0]        c_out,
    output logic                 r_d_wen_out,
    output logic [AW-1:0]        r_d_waddr_out,
    output logic [DW-1:0]        d_out
`ifdef RF_WSCHED_STATS_EN
    ,
    output logic [15:0]          grant_cnt_out,
    output logic [15:0]          conflict_cnt_out
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [AW-1:0] w_addr [NREQ];
    logic [DW-1:0] w_data [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_addr[g] = req_addr_in[g*AW +: AW];
        assign w_data[g] = req_data_in[g*DW +: DW];
    end

    logic [PW-1:0] r_rr_ptr;
    logic          w_c_hit;
    logic          w_d_hit;
    logic [PW-1:0] w_c_idx;
    logic [PW-1:0] w_d_idx;
    logic [AW-1:0] w_c_addr;
    logic [AW-1:0] w_d_addr;
    logic [DW-1:0] w_c_data;
    logic [DW-1:0] w_d_data;
`ifdef RF_WSCHED_STATS_EN
    logic          w_skip;
`endif

    // Scan pass 0 covers indices >= rr_ptr, pass 1 wraps to those below it.
    always_comb begin
        w_c_hit  = 1'b0;
        w_d_hit  = 1'b0;
        w_c_idx  = '0;
        w_d_idx  = '0;
        w_c_addr = '0;
        w_d_addr = '0;
        w_c_data = '0;
        w_d_data = '0;
`ifdef RF_WSCHED_STATS_EN
        w_skip   = 1'b0;
`endif
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (((p == 0) == (i >= int'(r_rr_ptr))) && req_valid_in[i]) begin
                    if (!w_c_hit) begin
                        w_c_hit  = 1'b1;
                        w_c_idx  = PW'(i);
                        w_c_addr = w_addr[i];
                        w_c_data = w_data[i];
                    end else if (!w_d_hit) begin
                        if (w_addr[i] != w_c_addr) begin
                            w_d_hit  = 1'b1;
                            w_d_idx  = PW'(i);
                            w_d_addr = w_addr[i];
                            w_d_data = w_data[i];
                        end
`ifdef RF_WSCHED_STATS_EN
                        else begin
                            w_skip = 1'b1;
                        end
`endif
                    end
                end
            end
        end
    end

    logic          w_en;
    logic          w_c_gnt;
    logic          w_d_gnt;
    logic [PW-1:0] w_last;
    logic [PW-1:0] w_rr_next;

    assign w_en      = sched_en_in & ~reset;
    assign w_c_gnt   = w_c_hit & w_en;
    assign w_d_gnt   = w_d_hit & w_en;
    assign w_last    = w_d_gnt ? w_d_idx : w_c_idx;
    assign w_rr_next = (w_last == PW'(NREQ - 1)) ? '0 : w_last + 1'b1;

    always_comb begin
        req_ready_out = '0;
        if (w_c_gnt) req_ready_out[w_c_idx] = 1'b1;
        if (w_d_gnt) req_ready_out[w_d_idx] = 1'b1;
    end

    logic          r_c_wen;
    logic [AW-1:0] r_c_waddr;
    logic [DW-1:0] r_c_data;
    logic          r_d_wen;
    logic [AW-1:0] r_d_waddr;
    logic [DW-1:0] r_d_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr  <= '0;
            r_c_wen   <= 1'b0;
            r_c_waddr <= '0;
            r_c_data  <= '0;
            r_d_wen   <= 1'b0;
            r_d_waddr <= '0;
            r_d_data  <= '0;
        end else begin
            r_c_wen   <= w_c_gnt;
            r_c_waddr <= w_c_gnt ? w_c_addr : '0;
            r_c_data  <= w_c_gnt ? w_c_data : '0;
            r_d_wen   <= w_d_gnt;
            r_d_waddr <= w_d_gnt ? w_d_addr : '0;
            r_d_data  <= w_d_gnt ? w_d_data : '0;
            if (w_c_gnt) r_rr_ptr <= w_rr_next;
        end
    end

    // Reset masks the registered writes so a grant made just before reset never lands in the file.
    assign r_c_wen_out   = r_c_wen & ~reset;
    assign r_c_waddr_out = reset ? '0 : r_c_waddr;
    assign c_out         = reset ? '0 : r_c_data;
    assign r_d_wen_out   = r_d_wen & ~reset;
    assign r_d_waddr_out = reset ? '0 : r_d_waddr;
    assign d_out         = reset ? '0 : r_d_data;

`ifdef RF_WSCHED_STATS_EN
    logic [15:0] r_grant_cnt;
    logic [15:0] r_conflict_cnt;
    logic [16:0] w_grant_sum;

    assign w_grant_sum = {1'b0, r_grant_cnt} + 17'(w_c_gnt) + 17'(w_d_gnt);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_grant_cnt    <= '0;
            r_conflict_cnt <= '0;
        end else begin
            r_grant_cnt <= w_grant_sum[16] ? 16'hFFFF : w_grant_sum[15:0];
            if (w_skip && w_en && (r_conflict_cnt != 16'hFFFF))
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign grant_cnt_out    = r_grant_cnt;
    assign conflict_cnt_out = r_conflict_cnt;
`endif

endmodule
